// File: rtl/prbs_iq_gen.sv
// prbs_iq_gen: spreads a latched PRBS code into 2-bit (magnitude/sign) I/Q samples.
// Supports a selectable carrier quadrant, code-phase offset, sample rate divider,
// a finite or endless period count and LFSR-driven sign-flip noise.
module prbs_iq_gen #(
    parameter int unsigned  PRBS_SIZE = 64,
    localparam int unsigned CW        = $clog2(PRBS_SIZE)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [PRBS_SIZE-1:0] code,
    input  logic [CW-1:0]        start_chip,
    input  logic [15:0]          rate_div,
    input  logic [15:0]          n_periods,
    input  logic                 amp,
    input  logic [1:0]           phase,
    input  logic                 noise_en,
    input  logic [7:0]           noise_thr,
    output logic                 I_mag,
    output logic                 I_sig,
    output logic                 Q_mag,
    output logic                 Q_sig,
    output logic                 oVld,
    output logic                 epoch,
    output logic                 busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [PRBS_SIZE-1:0] code_q, code_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        chip_q, chip_d;
    logic [15:0]          rate_q, rate_d;
    logic [15:0]          nper_q, nper_d;
    logic [15:0]          div_q, div_d;
    logic [15:0]          period_q, period_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 emit;

    logic                 i_mag_q, i_sig_q, q_mag_q, q_sig_q;
    logic                 vld_q, epoch_q, busy_q;

    logic                 base_sig;
    logic                 i_sig_d, q_sig_d;
    logic [7:0]           lfsr_swap;
    logic                 stop_only;

    assign stop_only = stop & ~start;

    // Next-state: configuration latch, rate divider, chip/period counters, LFSR.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        chip_d   = chip_q;
        rate_d   = rate_q;
        nper_d   = nper_q;
        div_d    = div_q;
        period_d = period_q;
        lfsr_d   = lfsr_q;
        emit     = 1'b0;
        if (start) begin
            // Restart reloads everything except the noise LFSR.
            state_d  = StRun;
            code_d   = code;
            idx_d    = CW'(32'(start_chip) % PRBS_SIZE);
            rate_d   = rate_div;
            nper_d   = n_periods;
            div_d    = '0;
            chip_d   = '0;
            period_d = '0;
        end else if (stop) begin
            state_d = StIdle;
        end else if (state_q == StRun) begin
            div_d = (div_q == rate_q) ? '0 : div_q + 16'd1;
            if (div_q == '0) begin
                emit   = 1'b1;
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                idx_d  = (idx_q == CW'(PRBS_SIZE - 1)) ? '0 : idx_q + CW'(1);
                // Period completion counts samples, so it ignores the start offset.
                if (chip_q == CW'(PRBS_SIZE - 1)) begin
                    chip_d   = '0;
                    period_d = period_q + 16'd1;
                    if (nper_q != 16'd0 && period_q == nper_q - 16'd1) begin
                        state_d = StIdle;
                    end
                end else begin
                    chip_d = chip_q + CW'(1);
                end
            end
        end
    end

    // Sample signs: quadrant mapping followed by optional noise flips.
    always_comb begin
        lfsr_swap = {lfsr_q[3:0], lfsr_q[7:4]};
        base_sig  = code_q[idx_q];
        i_sig_d   = base_sig ^ (phase[0] ^ phase[1]) ^ (noise_en & (lfsr_q < noise_thr));
        q_sig_d   = base_sig ^ phase[1] ^ (noise_en & (lfsr_swap < noise_thr));
    end

    // Control and counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            code_q   <= '0;
            idx_q    <= '0;
            chip_q   <= '0;
            rate_q   <= '0;
            nper_q   <= '0;
            div_q    <= '0;
            period_q <= '0;
            lfsr_q   <= 8'hFF;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            chip_q   <= chip_d;
            rate_q   <= rate_d;
            nper_q   <= nper_d;
            div_q    <= div_d;
            period_q <= period_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Registered outputs; sample bits hold between strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_mag_q <= 1'b0;
            i_sig_q <= 1'b0;
            q_mag_q <= 1'b0;
            q_sig_q <= 1'b0;
            vld_q   <= 1'b0;
            epoch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vld_q   <= emit;
            epoch_q <= emit & (idx_q == '0);
            // Lags the state by one edge so busy rises with the first strobe.
            busy_q  <= (state_q == StRun) & ~stop_only;
            if (emit) begin
                i_mag_q <= amp;
                q_mag_q <= amp;
                i_sig_q <= i_sig_d;
                q_sig_q <= q_sig_d;
            end
        end
    end

    assign I_mag = i_mag_q;
    assign I_sig = i_sig_q;
    assign Q_mag = q_mag_q;
    assign Q_sig = q_sig_q;
    assign oVld  = vld_q;
    assign epoch = epoch_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_prbs_iq_gen.sv
// Self-checking bench for prbs_iq_gen (PRBS_SIZE=8) against a strobe-schedule model.
module tb_prbs_iq_gen;

    localparam int unsigned P  = 8;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start, stop;
    logic [P-1:0]  code;
    logic [CW-1:0] start_chip;
    logic [15:0]   rate_div, n_periods;
    logic          amp;
    logic [1:0]    phase;
    logic          noise_en;
    logic [7:0]    noise_thr;
    logic          I_mag, I_sig, Q_mag, Q_sig, oVld, epoch, busy;

    prbs_iq_gen #(.PRBS_SIZE(P)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .code       (code),
        .start_chip (start_chip),
        .rate_div   (rate_div),
        .n_periods  (n_periods),
        .amp        (amp),
        .phase      (phase),
        .noise_en   (noise_en),
        .noise_thr  (noise_thr),
        .I_mag      (I_mag),
        .I_sig      (I_sig),
        .Q_mag      (Q_mag),
        .Q_sig      (Q_sig),
        .oVld       (oVld),
        .epoch      (epoch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: run schedule in terms of edges since start and strobes emitted.
    bit         m_run;
    logic [7:0] m_code;
    int         m_sc, m_rate, m_n;
    longint     m_t, m_k;
    logic [7:0] m_lfsr;
    logic       e_imag, e_isig, e_qmag, e_qsig, e_vld, e_epoch, e_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_lfsr = 8'hFF;
        m_t    = 0;
        m_k    = 0;
        {e_imag, e_isig, e_qmag, e_qsig, e_vld, e_epoch, e_busy} = '0;
    endtask

    // Apply one clock edge to the model using the inputs stable at that edge.
    task automatic model_edge();
        int   idx;
        logic s, i, q;
        e_vld   = 0;
        e_epoch = 0;
        e_busy  = m_run && !(stop && !start);
        if (start) begin
            m_run  = 1;
            m_code = code;
            m_sc   = int'(start_chip) % P;
            m_rate = int'(rate_div);
            m_n    = int'(n_periods);
            m_t    = 0;
            m_k    = 0;
        end else if (stop) begin
            m_run = 0;
        end else if (m_run) begin
            m_t++;
            if ((m_t - 1) % (m_rate + 1) == 0) begin
                idx = int'((m_sc + m_k) % P);
                s   = m_code[idx];
                i   = s ^ (phase == 2'd1 || phase == 2'd2);
                q   = s ^ (phase >= 2'd2);
                if (noise_en && m_lfsr < noise_thr) i = ~i;
                if (noise_en && {m_lfsr[3:0], m_lfsr[7:4]} < noise_thr) q = ~q;
                m_lfsr  = lfsr_step(m_lfsr);
                e_vld   = 1;
                e_epoch = (idx == 0);
                e_imag  = amp;
                e_qmag  = amp;
                e_isig  = i;
                e_qsig  = q;
                m_k++;
                if (m_n != 0 && m_k == longint'(m_n) * P) m_run = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("oVld",  32'(oVld),  32'(e_vld));
        check_eq("epoch", 32'(epoch), 32'(e_epoch));
        check_eq("busy",  32'(busy),  32'(e_busy));
        check_eq("I_mag", 32'(I_mag), 32'(e_imag));
        check_eq("Q_mag", 32'(Q_mag), 32'(e_qmag));
        check_eq("I_sig", 32'(I_sig), 32'(e_isig));
        check_eq("Q_sig", 32'(Q_sig), 32'(e_qsig));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
        start = 0;
        stop  = 0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic reset_mid();
        #2;
        resetn = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        resetn = 1;
    endtask

    task automatic set_cfg(input logic [7:0] c, input int sc, input int rd, input int np);
        code       = c;
        start_chip = CW'(sc);
        rate_div   = 16'(rd);
        n_periods  = 16'(np);
        start      = 1;
    endtask

    initial begin
        int len;
        resetn = 0; start = 0; stop = 0; code = '0; start_chip = '0;
        rate_div = '0; n_periods = '0; amp = 0; phase = '0; noise_en = 0; noise_thr = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        resetn = 1;
        repeat (2) cycle();

        // Basic pattern.
        amp = 1; phase = 0; noise_en = 0;
        set_cfg(8'hB4, 0, 0, 1);
        repeat (12) cycle();

        // Offset and wrap over two periods.
        set_cfg(8'hB4, 6, 0, 2);
        repeat (20) cycle();

        // Rate divider and quadrant, with a mid-run phase change.
        amp = 0; phase = 2;
        set_cfg(8'hB4, 0, 3, 1);
        for (int c = 0; c < 36; c++) begin
            if (c == 14) phase = 1;
            cycle();
        end

        // Noise enabled with zero threshold never flips.
        amp = 1; phase = 0; noise_en = 1; noise_thr = 8'h00;
        set_cfg(8'h5A, 0, 0, 1);
        repeat (10) cycle();

        // Full threshold right after reset: lfsr=FF on the first strobe only.
        reset_mid();
        noise_thr = 8'hFF;
        set_cfg(8'h00, 0, 0, 1);
        repeat (10) cycle();

        // Randomized runs with live inputs and occasional stop/restart.
        for (int r = 0; r < 10; r++) begin
            set_cfg(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 3)));
            len = int'(n_periods) * P * (int'(rate_div) + 1) + 4;
            for (int c = 0; c < len; c++) begin
                amp       = 1'($urandom);
                phase     = 2'($urandom);
                noise_en  = 1'($urandom);
                noise_thr = 8'($urandom);
                if (c > 0) begin
                    if ($urandom_range(0, 59) == 0) stop = 1;
                    if ($urandom_range(0, 79) == 0) start = 1;
                end
                cycle();
            end
        end

        // Endless mode keeps running, then stop halts it.
        noise_en = 0; amp = 1; phase = 0;
        set_cfg(8'hC3, 0, 0, 0);
        repeat (1005) cycle();
        check_eq("endless_busy", 32'(busy), 32'd1);
        stop = 1;
        cycle();
        repeat (3) cycle();

        // Start and stop together: start wins and restarts at start_chip.
        set_cfg(8'hB4, 0, 1, 1);
        repeat (5) cycle();
        set_cfg(8'hB4, 5, 0, 1);
        stop = 1;
        repeat (12) cycle();

        // Stop mid-run.
        set_cfg(8'h96, 2, 0, 2);
        repeat (4) cycle();
        stop = 1;
        repeat (5) cycle();

        // Reset mid-run, then stay idle.
        set_cfg(8'hB4, 0, 0, 0);
        repeat (5) cycle();
        reset_mid();
        repeat (5) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
